// File: rtl/sseg_scroll_ctrl.sv
// Scrolling message sequencer for the seven-segment display controller.
// Presents an n_digits-wide window of a segment-pattern buffer and advances it on display frame syncs.
module sseg_scroll_ctrl #(
    parameter int n_digits = 8,
    parameter int n_segs   = 8,
    parameter int aw       = 5
) (
    input  logic                         clk_i,
    input  logic                         async_rst_n_i,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic [aw-1:0]                wr_addr_i,
    input  logic [n_segs-1:0]            wr_data_i,
    input  logic [aw:0]                  len_i,
    input  logic                         wrap_i,
    input  logic [7:0]                   fps_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic                         sync_i,
    output logic [n_digits*n_segs-1:0]   segments_o,
    output logic                         busy_o,
    output logic                         step_o,
    output logic                         done_o
);

    localparam int          depth     = 2**aw;
    localparam logic [aw:0] depth_len = (aw+1)'(depth);
    localparam logic [aw:0] ndig_len  = (aw+1)'(n_digits);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                       state_q, state_d;
    logic [aw-1:0]                pos_q, pos_d;
    logic [7:0]                   frame_cnt_q, frame_cnt_d;
    logic [aw:0]                  len_q, len_d;
    logic                         wrap_q, wrap_d;
    logic                         step_q, step_d;
    logic                         done_q, done_d;
    logic [n_digits*n_segs-1:0]   seg_q, seg_d;
    logic [n_segs-1:0]            buf_q [depth];

    logic        start_ok;
    logic        frame_hit;
    logic        at_end;
    logic        refresh;
    logic [aw:0] last_pos;

    assign start_ok  = start_i && !stop_i && (len_i != '0);
    assign frame_hit = sync_i && (state_q == RUN) && (frame_cnt_q >= fps_i);
    assign last_pos  = (len_q > ndig_len) ? (len_q - ndig_len) : '0;
    assign at_end    = ({1'b0, pos_q} == last_pos);
    assign refresh   = sync_i || start_ok;

    // Buffer: register array so that reset can clear every entry.
    always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) begin
            for (int i = 0; i < depth; i++) buf_q[i] <= '0;
        end else if (rst_i) begin
            for (int i = 0; i < depth; i++) buf_q[i] <= '0;
        end else if (wr_en_i) begin
            buf_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) begin
            state_q <= IDLE;
        end else if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = IDLE;
        end else if (start_ok) begin
            state_d = RUN;
        end else if (frame_hit && !wrap_q && at_end) begin
            state_d = HOLD;
        end
    end

    always_comb begin
        busy_o     = (state_q == RUN);
        segments_o = seg_q;
        step_o     = step_q;
        done_o     = done_q;
    end

    always_comb begin
        pos_d       = pos_q;
        frame_cnt_d = frame_cnt_q;
        len_d       = len_q;
        wrap_d      = wrap_q;
        step_d      = 1'b0;
        done_d      = 1'b0;
        if (stop_i) begin
            pos_d = pos_q;
        end else if (start_ok) begin
            len_d       = (len_i > depth_len) ? depth_len : len_i;
            wrap_d      = wrap_i;
            pos_d       = '0;
            frame_cnt_d = '0;
        end else if (sync_i && (state_q == RUN)) begin
            if (frame_hit) begin
                frame_cnt_d = '0;
                if (wrap_q) begin
                    pos_d  = ({1'b0, pos_q} == len_q - 1'b1) ? '0 : pos_q + 1'b1;
                    step_d = 1'b1;
                end else if (at_end) begin
                    done_d = 1'b1;
                end else begin
                    pos_d  = pos_q + 1'b1;
                    step_d = 1'b1;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // Window is built from the post-step position so a sync refreshes with the new view.
    logic [aw-1:0] widx [n_digits];

    genvar gi;
    generate
        for (gi = 0; gi < n_digits; gi++) begin : g_digit
            logic [aw:0]       j;
            logic [n_segs-1:0] ch;

            assign j = {1'b0, pos_d} + (aw+1)'(gi);

            if (gi == 0) begin : g_first
                assign widx[gi] = pos_d;
            end else begin : g_next
                assign widx[gi] = ({1'b0, widx[gi-1]} == len_d - 1'b1) ? '0 : widx[gi-1] + 1'b1;
            end

            always_comb begin
                ch = '0;
                if (wrap_d) begin
                    ch = buf_q[widx[gi]];
                end else if (j < len_d) begin
                    ch = buf_q[j[aw-1:0]];
                end
            end

            assign seg_d[n_segs*(n_digits-gi)-1 -: n_segs] = ch;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) begin
            pos_q       <= '0;
            frame_cnt_q <= '0;
            len_q       <= '0;
            wrap_q      <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            seg_q       <= '0;
        end else if (rst_i) begin
            pos_q       <= '0;
            frame_cnt_q <= '0;
            len_q       <= '0;
            wrap_q      <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            seg_q       <= '0;
        end else begin
            pos_q       <= pos_d;
            frame_cnt_q <= frame_cnt_d;
            len_q       <= len_d;
            wrap_q      <= wrap_d;
            step_q      <= step_d;
            done_q      <= done_d;
            if (refresh) seg_q <= seg_d;
        end
    end

endmodule

// File: doc/sseg_scroll_ctrl.md
Name: sseg_scroll_ctrl

Overview:
- Message sequencer feeding the segments_i bus of the seven-segment display controller.
- Holds a buffer of raw segment patterns and presents an n_digits-wide window of that buffer.
- Advances the window one character every programmable number of display frames, counted on the display controller's sync_o pulse.
- Supports wrap-around (marquee) and one-shot (stop at end) modes, with busy/step/done status for a bus wrapper or CPU.

Parameters:
n_digits, 8, number of display digits (window width)
n_segs, 8, bits per character pattern
aw, 5, buffer address width; buffer depth = 2**aw (32)

Ports:
clk_i  in  1  system clock
async_rst_n_i  in  1  asynchronous reset, active-low
rst_i  in  1  synchronous reset, active-high
wr_en_i  in  1  buffer write strobe
wr_addr_i  in  aw  buffer write address
wr_data_i  in  n_segs  segment pattern to write
len_i  in  aw+1  message length in characters, sampled at start
wrap_i  in  1  1 = wrap-around mode, 0 = one-shot mode; sampled at start
fps_i  in  8  frames per step minus 1; used live
start_i  in  1  start pulse
stop_i  in  1  stop pulse
sync_i  in  1  end-of-frame pulse (from display controller sync_o)
segments_o  out  n_digits*n_segs  window; digit k at [n_segs*(n_digits-k)-1 -: n_segs], k=0 leftmost
busy_o  out  1  state == RUN
step_o  out  1  one-cycle pulse, cycle after a window advance
done_o  out  1  one-cycle pulse, cycle after one-shot end reached

Behaviour:
- Reset (async_rst_n_i low, or rst_i high at the clock edge):
  - state IDLE; pos, frame_cnt, len_reg and wrap_reg = 0.
  - All buffer entries = 0; segments_o, busy_o, step_o, done_o = 0.
  - Writes during reset are ignored.
- Buffer:
  - wr_en_i writes wr_data_i to buf[wr_addr_i] in any state.
  - A write coincident with a refresh is not visible in that refresh (old data used).
- Start:
  - start_i with len_i == 0 is ignored.
  - Otherwise: len_reg = min(len_i, 2**aw); wrap_reg = wrap_i; pos = 0; frame_cnt = 0; state RUN.
  - segments_o shows window(0) the following cycle.
  - Start is accepted from any state, so it restarts a running or held scroll.
- Stop: stop_i forces IDLE from any state; pos is kept. If start_i and stop_i are asserted in the same cycle, stop wins.
- FSM states:
  - IDLE: no stepping.
  - RUN: stepping as below.
  - HOLD: one-shot finished; no stepping; window frozen at last_pos.
- Frame counting (sync_i in RUN):
  - If frame_cnt >= fps_i: frame_cnt = 0 and a step occurs.
  - Otherwise frame_cnt += 1.
  - A step therefore occurs every fps_i+1 frames. fps_i = 0 steps on every frame. A live fps_i decrease below frame_cnt steps on the next sync.
- Step, wrap mode: pos = (pos == len_reg-1) ? 0 : pos+1. Never completes.
- Step, one-shot mode:
  - last_pos = (len_reg > n_digits) ? len_reg-n_digits : 0.
  - If pos == last_pos: state HOLD, done_o pulses, pos unchanged, no step_o.
  - Else pos += 1 and step_o pulses.
- Window contents:
  - Digit k shows buf[idx], where j = pos+k.
  - Wrap mode: idx = j mod len_reg (wraps through the message start).
  - One-shot mode: idx = j if j < len_reg, else blank (all zeros).
- Refresh timing:
  - segments_o is registered and updated only on sync_i (every state) or on an accepted start. This keeps the display tear-free.
  - The refresh on a sync uses the post-step pos of that same sync, so latency from sync_i to the new segments_o is 1 cycle.
  - step_o and done_o are asserted in the same cycle the new segments_o appears.
- Widths: pos and frame_cnt are wrap-free by construction. pos+k is computed in aw+1 bits before reduction.

Test Plan:
- Load buf[i]=i+1 (i=0..11), len 12, wrap 0, fps 0, start:
  - After start: window 01..08.
  - Sync 1: 02..09, step_o.
  - Sync 4: 05..0C.
  - Sync 5: done_o, busy_o=0, window stays 05..0C; later syncs change nothing.
- Same buffer, len 10, wrap 1, fps 2:
  - Steps on syncs 3, 6, 9…
  - After 15 syncs pos=5, window 06,07,08,09,0A,01,02,03.
  - After 30 syncs pos=0; done_o never pulses.
- len 3, wrap 0, start:
  - Window 01,02,03,00,00,00,00,00.
  - First sync: done_o, HOLD, no step_o.
- Interrupting a run:
  - stop_i at pos 2: busy_o=0, further syncs keep window at pos 2.
  - start_i+stop_i in the same cycle: remains IDLE.
  - start_i during HOLD: restarts at pos 0.
- Resets and length limits:
  - async_rst_n_i low mid-run: segments_o=0 immediately, busy_o=0, buffer cleared.
  - rst_i gives the same result at the next edge.
  - start with len 0: ignored.
  - start with len 40 and wrap 1: wraps after pos 31.
